// File: rtl/seq_arith_unit.sv
// Handshaked unsigned ADD/SUB (1-cycle) and iterative shift-add MUL (WIDTH steps).
// Optional saturation of ADD carry / SUB borrow is enabled by defining SEQ_ARITH_UNIT_SAT_EN.
module seq_arith_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic               out_err,
    output logic               out_sat
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {IDLE, MUL_BUSY, DONE} state_t;

    state_t               state_reg, state_next;
    logic [2*WIDTH:0]     acc_reg, acc_next, acc_step;
    logic [WIDTH-1:0]     mcand_reg, mcand_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [2*WIDTH-1:0]   result_reg, result_next;
    logic                 err_reg, err_next;
    logic                 sat_reg, sat_next;
    logic [WIDTH:0]       sum_w, diff_w;

    function automatic logic [WIDTH:0] add_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Bit WIDTH of the widened difference is the borrow (a < b).
    function automatic logic [WIDTH:0] sub_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    // Accumulator holds {partial product (WIDTH+1 bits), remaining multiplier bits}.
    task automatic shift_add_step(input  logic [2*WIDTH:0] acc,
                                  input  logic [WIDTH-1:0] mcand,
                                  output logic [2*WIDTH:0] acc_out);
        logic [WIDTH:0] upper;
        upper = acc[2*WIDTH:WIDTH];
        if (acc[0])
            upper = upper + {1'b0, mcand};
        acc_out = {upper, acc[WIDTH-1:0]} >> 1;
    endtask

    assign sum_w  = add_f(in_a, in_b);
    assign diff_w = sub_f(in_a, in_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
            sat_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            err_reg    <= err_next;
            sat_reg    <= sat_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        err_next    = err_reg;
        sat_next    = sat_reg;
        shift_add_step(acc_reg, mcand_reg, acc_step);

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    err_next   = 1'b0;
                    sat_next   = 1'b0;
                    state_next = DONE;
                    case (in_op)
                        OP_ADD: begin
                            result_next = {{(WIDTH-1){1'b0}}, sum_w};
`ifdef SEQ_ARITH_UNIT_SAT_EN
                            if (sum_w[WIDTH]) begin
                                result_next = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                                sat_next    = 1'b1;
                            end
`endif
                        end
                        OP_SUB: begin
                            result_next = {{(WIDTH-1){1'b0}}, diff_w};
`ifdef SEQ_ARITH_UNIT_SAT_EN
                            if (diff_w[WIDTH]) begin
                                result_next = '0;
                                sat_next    = 1'b1;
                            end
`endif
                        end
                        OP_MUL: begin
                            mcand_next = in_a;
                            acc_next   = {{(WIDTH+1){1'b0}}, in_b};
                            cnt_next   = '0;
                            state_next = MUL_BUSY;
                        end
                        default: begin
                            result_next = '0;
                            err_next    = 1'b1;
                        end
                    endcase
                end
            end
            MUL_BUSY: begin
                // Full WIDTH steps regardless of operand values; one extra cycle publishes the product.
                if (cnt_reg == CNT_W'(WIDTH)) begin
                    result_next = acc_reg[2*WIDTH-1:0];
                    state_next  = DONE;
                end else begin
                    acc_next = acc_step;
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign out_result = result_reg;
    assign out_err    = err_reg;
    assign out_sat    = sat_reg;
endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed table-driven bench for seq_arith_unit at WIDTH=8, plus backpressure and mid-op reset sequences.
module tb_seq_arith_unit;
    localparam int W = 8;
`ifdef SEQ_ARITH_UNIT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [1:0]     in_op = 2'b00;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] out_result;
    logic           out_err;
    logic           out_sat;

    int n_cmp = 0;
    int n_err = 0;

    seq_arith_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_err(out_err), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        err;
        logic        sat;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called #1 after an edge with the DUT idle; returns after the output handshake.
    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] res, output logic err, output logic sat, output int lat);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0; in_op = OP_ILL; in_a = ~a; in_b = ~b;
        lat = 0;
        while (!out_valid && lat < 40) begin
            check("busy_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        res = out_result; err = out_err; sat = out_sat;
        @(posedge clk); #1;
        check("valid_after_hs", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [15:0] r;
        logic        e, s;
        int          l;

        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] r;
        logic        e, s;
        int          l;

        vecs[0]  = '{OP_ADD, 8'd200, 8'd100, SAT ? 16'h00FF : 16'h012C, 1'b0, SAT,  0};
        vecs[1]  = '{OP_SUB, 8'd5,   8'd7,   SAT ? 16'h0000 : 16'h01FE, 1'b0, SAT,  0};
        vecs[2]  = '{OP_SUB, 8'd7,   8'd5,   16'h0002,                  1'b0, 1'b0, 0};
        vecs[3]  = '{OP_MUL, 8'd255, 8'd255, 16'hFE01,                  1'b0, 1'b0, 9};
        vecs[4]  = '{OP_MUL, 8'd13,  8'd11,  16'h008F,                  1'b0, 1'b0, 9};
        vecs[5]  = '{OP_ILL, 8'd9,   8'd9,   16'h0000,                  1'b1, 1'b0, 0};
        vecs[6]  = '{OP_ADD, 8'd1,   8'd2,   16'h0003,                  1'b0, 1'b0, 0};
        vecs[7]  = '{OP_MUL, 8'd0,   8'd200, 16'h0000,                  1'b0, 1'b0, 9};
        vecs[8]  = '{OP_MUL, 8'd200, 8'd0,   16'h0000,                  1'b0, 1'b0, 9};
        vecs[9]  = '{OP_ADD, 8'd255, 8'd255, SAT ? 16'h00FF : 16'h01FE, 1'b0, SAT,  0};
        vecs[10] = '{OP_SUB, 8'd0,   8'd0,   16'h0000,                  1'b0, 1'b0, 0};
        vecs[11] = '{OP_MUL, 8'd3,   8'd4,   16'h000C,                  1'b0, 1'b0, 9};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_out_valid",  {31'd0, out_valid}, 32'd0);
        check("rst_out_result", {16'd0, out_result}, 32'd0);
        check("rst_out_err",    {31'd0, out_err}, 32'd0);
        check("rst_out_sat",    {31'd0, out_sat}, 32'd0);
        check("rst_in_ready",   {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, e, s, l);
            $display("txn %0d op=%0d a=%0d b=%0d result=0x%04h err=%0b sat=%0b lat=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, r, e, s, l);
            check($sformatf("v%0d_result", i), {16'd0, r}, {16'd0, vecs[i].res});
            check($sformatf("v%0d_err", i),    {31'd0, e}, {31'd0, vecs[i].err});
            check($sformatf("v%0d_sat", i),    {31'd0, s}, {31'd0, vecs[i].sat});
            check($sformatf("v%0d_latency", i), l, vecs[i].lat);
        end

        // Backpressure: MUL 3*4 held in DONE while a pending ADD 1+1 waits on in_valid.
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = OP_MUL; in_a = 8'd3; in_b = 8'd4;
        @(posedge clk); #1;
        in_op = OP_ADD; in_a = 8'd1; in_b = 8'd1;
        l = 0;
        while (!out_valid && l < 40) begin
            @(posedge clk); #1;
            l++;
        end
        check("bp_latency", l, 9);
        for (int c = 0; c < 5; c++) begin
            check("bp_out_valid",  {31'd0, out_valid}, 32'd1);
            check("bp_out_result", {16'd0, out_result}, 32'h000C);
            check("bp_in_ready",   {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_hs_valid", {31'd0, out_valid}, 32'd0);
        check("bp_hs_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_valid",  {31'd0, out_valid}, 32'd1);
        check("bp_next_result", {16'd0, out_result}, 32'h0002);
        $display("txn bp op=MUL a=3 b=4 then ADD 1+1 result=0x%04h", out_result);
        @(posedge clk); #1;

        // Reset during the 4th MUL_BUSY cycle aborts the multiply.
        in_valid = 1'b1; in_op = OP_MUL; in_a = 8'd255; in_b = 8'd255;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_valid",  {31'd0, out_valid}, 32'd0);
        check("mid_rst_result", {16'd0, out_result}, 32'd0);
        check("mid_rst_ready",  {31'd0, in_ready}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("mid_rst_no_late_valid", {31'd0, out_valid}, 32'd0);
        run_op(OP_ADD, 8'd1, 8'd1, r, e, s, l);
        $display("txn rst op=ADD a=1 b=1 result=0x%04h err=%0b sat=%0b lat=%0d", r, e, s, l);
        check("post_rst_result",  {16'd0, r}, 32'h0002);
        check("post_rst_latency", l, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
